fft_bitrev_reorder: RTL and testbench

- Output-side consumer for the streaming 64-point FFT.
- Accepts complete FFT frames arriving in bit-reversed index order on a valid/last stream.
- Re-emits each frame in natural order (bin 0..POINTS-1) to downstream logic that may apply backpressure.
- Ping-pong double buffer so back-to-back frames stream at full rate when downstream is always ready.

---
 rtl/fft_stream_pkg.sv | 22 ++
 rtl/fft_pingpong_ram.sv | 28 ++
 rtl/fft_bitrev_reorder.sv | 134 +++++++++++++
 tb/tb_fft_bitrev_reorder.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_stream_pkg.sv
// Shared constants and index helpers for the streaming FFT datapath.
// Used by the FFT core and its output-side reorder stage.
package fft_stream_pkg;

    localparam int DATA_W = 20;
    localparam int POINTS = 64;
    localparam int ADDR_W = $clog2(POINTS);

    // Reverse the low w bits of a; w is a constant at every call site.
    function automatic int unsigned bitrev(input int unsigned a,
                                           input int unsigned w);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(w)) begin
                r[w - 1 - i] = a[i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: one synchronous write port, one asynchronous
// read port; bank select is the top address bit.
module fft_pingpong_ram #(
    parameter int DATA_W = 20,
    parameter int POINTS = 64,
    parameter int ADDR_W = $clog2(POINTS)
) (
    input  logic                clk,
    input  logic                wr_en,
    input  logic                wr_bank,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [2*DATA_W-1:0] wr_data,
    input  logic                rd_bank,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [2*DATA_W-1:0] rd_data
);

    logic [2*DATA_W-1:0] mem [2*POINTS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_bank, wr_addr}] <= wr_data;
        end
    end

    assign rd_data = mem[{rd_bank, rd_addr}];

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Turns bit-reversed FFT frames into natural-order frames through a
// ping-pong buffer, with a backpressured registered output stage.
module fft_bitrev_reorder #(
    parameter int DATA_W = fft_stream_pkg::DATA_W,
    parameter int POINTS = fft_stream_pkg::POINTS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] real_in,
    input  logic [DATA_W-1:0] imag_in,
    input  logic              valid_in,
    input  logic              last_in,
    output logic [DATA_W-1:0] real_out,
    output logic [DATA_W-1:0] imag_out,
    output logic              valid_out,
    input  logic              ready_out,
    output logic              last_out,
    output logic              done,
    output logic              overflow,
    output logic              frame_err
);

    import fft_stream_pkg::*;

    localparam int ADDR_W = $clog2(POINTS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(POINTS - 1);

    logic [ADDR_W-1:0]   wr_cnt;
    logic [ADDR_W-1:0]   rd_cnt;
    logic                wr_bank;
    logic                rd_bank;
    logic [1:0]          full;
    logic                wr_ok;
    logic                wr_end;
    logic                commit;
    logic [ADDR_W-1:0]   wr_addr;
    logic                load;
    logic                rd_end;
    logic                release_bank;
    logic [1:0]          set_mask;
    logic [1:0]          clr_mask;
    logic [2*DATA_W-1:0] rd_data;

    assign wr_ok   = valid_in && !full[wr_bank];
    assign wr_end  = wr_cnt == LAST_IDX;
    assign commit  = wr_ok && wr_end;
    assign wr_addr = ADDR_W'(bitrev(32'(wr_cnt), ADDR_W));

    assign load         = (!valid_out || ready_out) && full[rd_bank];
    assign rd_end       = rd_cnt == LAST_IDX;
    assign release_bank = load && rd_end;

    // Commit and release never target the same bank: a full bank drops writes.
    assign set_mask = commit ? (2'b01 << wr_bank) : 2'b00;
    assign clr_mask = release_bank ? (2'b01 << rd_bank) : 2'b00;

    fft_pingpong_ram #(
        .DATA_W (DATA_W),
        .POINTS (POINTS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_bank (wr_bank),
        .wr_addr (wr_addr),
        .wr_data ({real_in, imag_in}),
        .rd_bank (rd_bank),
        .rd_addr (rd_cnt),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (valid_in) begin
                if (full[wr_bank]) begin
                    overflow <= 1'b1;
                end else if (wr_end) begin
                    wr_cnt    <= '0;
                    wr_bank   <= ~wr_bank;
                    frame_err <= !last_in;
                end else if (last_in) begin
                    wr_cnt    <= '0;
                    frame_err <= 1'b1;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 2'b00;
        end else begin
            full <= (full | set_mask) & ~clr_mask;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt    <= '0;
            rd_bank   <= 1'b0;
            real_out  <= '0;
            imag_out  <= '0;
            valid_out <= 1'b0;
            last_out  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= valid_out && ready_out && last_out;
            if (load) begin
                real_out  <= rd_data[2*DATA_W-1:DATA_W];
                imag_out  <= rd_data[DATA_W-1:0];
                valid_out <= 1'b1;
                last_out  <= rd_end;
                if (rd_end) begin
                    rd_cnt  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end else if (ready_out) begin
                valid_out <= 1'b0;
                last_out  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for the bit-reverse reorder stage.
// Stimulus queues expected bins; a negedge monitor checks outputs.
module tb_fft_bitrev_reorder;

    localparam int DATA_W = 20;
    localparam int NPTS   = 64;

    typedef struct {
        logic signed [DATA_W-1:0] re;
        logic signed [DATA_W-1:0] im;
        logic                     last;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [DATA_W-1:0] real_in;
    logic [DATA_W-1:0] imag_in;
    logic              valid_in;
    logic              last_in;
    logic [DATA_W-1:0] real_out;
    logic [DATA_W-1:0] imag_out;
    logic              valid_out;
    logic              ready_out;
    logic              last_out;
    logic              done;
    logic              overflow;
    logic              frame_err;

    exp_t q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   out_cnt    = 0;
    int   ferr_cnt   = 0;
    int   rise_cnt   = 0;
    int   rdy_mode   = 1;
    logic mon_en     = 1'b0;
    logic exp_done   = 1'b0;
    logic prev_valid = 1'b0;

    fft_bitrev_reorder #(
        .DATA_W (DATA_W),
        .POINTS (NPTS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .real_in   (real_in),
        .imag_in   (imag_in),
        .valid_in  (valid_in),
        .last_in   (last_in),
        .real_out  (real_out),
        .imag_out  (imag_out),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .last_out  (last_out),
        .done      (done),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    function automatic int brev(input int k);
        int r;
        r = 0;
        for (int b = 0; b < 6; b++) begin
            if (k[b]) r = r | (1 << (5 - b));
        end
        return r;
    endfunction

    task automatic check(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push_frame(input int off);
        exp_t e;
        int   v;
        for (int k = 0; k < NPTS; k++) begin
            v      = off + brev(k);
            e.re   = DATA_W'(v);
            e.im   = DATA_W'(-v);
            e.last = (k == NPTS - 1);
            q.push_back(e);
        end
    endtask

    task automatic send_frame(input int off, input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b1;
            real_in  = DATA_W'(off + i);
            imag_in  = DATA_W'(-(off + i));
            last_in  = (i == last_at);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain", q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input int target, input int budget);
        int n;
        n = 0;
        while (out_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_out", out_cnt, target);
    endtask

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       ready_out = 1'b0;
            1:       ready_out = 1'b1;
            default: ready_out = ~ready_out;
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        if (!mon_en || !rst) begin
            exp_done   = 1'b0;
            prev_valid = 1'b0;
        end else begin
            if (done || exp_done) begin
                compared++;
                if (done !== exp_done) begin
                    mismatched++;
                    $display("FAIL done: got %0b want %0b", done, exp_done);
                end
            end
            exp_done = valid_out && ready_out && last_out;
            if (frame_err) ferr_cnt++;
            if (valid_out && !prev_valid) rise_cnt++;
            prev_valid = valid_out;
            if (valid_out) begin
                compared++;
                if (q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected out: got re=%0d want none",
                             $signed(real_out));
                end else begin
                    e = q[0];
                    if (real_out !== e.re || imag_out !== e.im ||
                        last_out !== e.last) begin
                        mismatched++;
                        $display("FAIL out[%0d]: got %0d,%0d,%0b want %0d,%0d,%0b",
                                 out_cnt, $signed(real_out), $signed(imag_out),
                                 last_out, e.re, e.im, e.last);
                    end
                    if (ready_out) begin
                        void'(q.pop_front());
                        out_cnt++;
                    end
                end
            end
        end
    end

    initial begin
        int base;
        int f0;
        int r0;
        rst      = 1'b0;
        real_in  = '0;
        imag_in  = '0;
        valid_in = 1'b0;
        last_in  = 1'b0;
        ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst valid_out", valid_out, 0);
        check("rst last_out", last_out, 0);
        check("rst done", done, 0);
        check("rst overflow", overflow, 0);
        check("rst frame_err", frame_err, 0);
        rst = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(posedge clk);

        // single frame, latency
        rdy_mode = 1;
        push_frame(0);
        send_frame(0, NPTS, NPTS - 1);
        idle();
        check("lat valid low", valid_out, 0);
        @(posedge clk);
        #1;
        check("lat valid high", valid_out, 1);
        check("lat bin0", int'($signed(real_out)), 0);
        wait_drain(200);
        check("t1 frame_err", ferr_cnt, 0);

        // back-to-back frames
        base = out_cnt;
        r0   = rise_cnt;
        push_frame(0);
        push_frame(100);
        push_frame(200);
        send_frame(0, NPTS, NPTS - 1);
        send_frame(100, NPTS, NPTS - 1);
        send_frame(200, NPTS, NPTS - 1);
        idle();
        wait_drain(400);
        check("b2b count", out_cnt - base, 192);
        check("b2b contiguous", rise_cnt - r0, 1);
        check("b2b overflow", overflow, 0);

        // toggled ready
        rdy_mode = 2;
        push_frame(300);
        send_frame(300, NPTS, NPTS - 1);
        idle();
        wait_drain(400);

        // stalled downstream, third frame dropped
        rdy_mode = 0;
        f0 = ferr_cnt;
        push_frame(1000);
        push_frame(2000);
        send_frame(1000, NPTS, NPTS - 1);
        send_frame(2000, NPTS, NPTS - 1);
        send_frame(3000, NPTS, NPTS - 1);
        idle();
        check("ovf set", overflow, 1);
        check("ovf no ferr", ferr_cnt - f0, 0);
        rdy_mode = 1;
        wait_drain(400);
        check("ovf sticky", overflow, 1);

        // framing errors
        f0   = ferr_cnt;
        base = out_cnt;
        send_frame(4000, 11, 10);
        idle();
        repeat (4) @(posedge clk);
        #1;
        check("short ferr", ferr_cnt - f0, 1);
        check("short no out", out_cnt - base, 0);
        push_frame(5000);
        send_frame(5000, NPTS, NPTS - 1);
        idle();
        wait_drain(200);
        push_frame(6000);
        send_frame(6000, NPTS, -1);
        idle();
        wait_drain(200);
        check("nolast ferr", ferr_cnt - f0, 2);

        // reset mid-output
        base = out_cnt;
        push_frame(7000);
        send_frame(7000, NPTS, NPTS - 1);
        idle();
        wait_out(base + 20, 200);
        #1;
        rst = 1'b0;
        #1;
        check("mid rst valid", valid_out, 0);
        check("mid rst last", last_out, 0);
        check("mid rst done", done, 0);
        check("mid rst ovf", overflow, 0);
        q.delete();
        @(posedge clk);
        #3;
        rst = 1'b1;
        push_frame(8000);
        send_frame(8000, NPTS, NPTS - 1);
        idle();
        wait_drain(200);

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
